// File: rtl/acc_fetch_if.sv
// ---------------------------------------------------------------------------
// acc_fetch_if
// Program-ROM read bus between the ACC fetch stage and the program ROM.
//   rom_addr : word address presented by the fetch stage (its Z register)
//   rom_cs   : chip select / read strobe, one cycle per read
//   rom_data : read data, valid ROM_LAT cycles after the strobe was sampled
// Modports:
//   master : fetch stage side (drives address and strobe)
//   slave  : ROM side (returns data)
// ---------------------------------------------------------------------------
interface acc_fetch_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [DW-1:0] rom_data;

    modport master (
        output rom_addr,
        output rom_cs,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  rom_cs,
        output rom_data
    );
endinterface

// File: rtl/acc_fetch.sv
// ---------------------------------------------------------------------------
// acc_fetch
// Instruction fetch/decode stage of the ACC CPU core. A rising edge on the
// debounced step level reads the program word at Z from the ROM, latches it
// into the instruction register, checks its parity, advances Z and drives
// the LED byte.
//
// Ports:
//   clk        : system clock, all logic on posedge
//   rst        : synchronous, active-low reset
//   step       : debounced step level; a fetch starts on its rising edge
//   pc_load    : load Z from pc_din (only honoured while idle)
//   pc_din     : new Z value
//   bus        : ROM read bus (master side: rom_addr, rom_cs / rom_data)
//   ir         : instruction register
//   opcode     : ir[14:12]
//   operand    : ir[11:0]
//   ir_valid   : one-cycle pulse when ir has just been updated
//   parity_err : odd-parity check result for the current ir
//   busy       : fetch in progress
//   pc         : current Z
//   disp_sel   : LED byte select (1 = low byte)
//   leds       : selected byte of ir
// ---------------------------------------------------------------------------
module acc_fetch #(
    parameter int            AW        = 12,
    parameter int            DW        = 16,
    parameter logic [AW-1:0] BOOT_ADDR = 12'h800,
    parameter int            ROM_LAT   = 1,     // legal range 1..3
    parameter bit            PAR_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                pc_load,
    input  logic [AW-1:0]       pc_din,
    acc_fetch_if.master         bus,
    output logic [DW-1:0]       ir,
    output logic [2:0]          opcode,
    output logic [AW-1:0]       operand,
    output logic                ir_valid,
    output logic                parity_err,
    output logic                busy,
    output logic [AW-1:0]       pc,
    input  logic                disp_sel,
    output logic [7:0]          leds
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Two bits cover the whole legal latency range (ROM_LAT-1 <= 2).
    localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] z_q, z_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          parity_err_q, parity_err_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          step_edge;

    // step_q resets to 1 so a button already held when reset releases does
    // not look like a fresh press.
    assign step_edge = step & ~step_q;

    always_comb begin
        state_d      = state_q;
        z_d          = z_q;
        ir_d         = ir_q;
        ir_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        cnt_d        = cnt_q;
        step_d       = step;

        case (state_q)
            S_IDLE: begin
                // pc_load wins over a simultaneous press; the press is lost.
                if (pc_load) begin
                    z_d = pc_din;
                end else if (step_edge) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    ir_d         = bus.rom_data;
                    // Odd parity expected: an even popcount is an error.
                    parity_err_d = PAR_EN & ~(^bus.rom_data);
                    z_d          = z_q + 1'b1;
                    ir_valid_d   = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            z_q          <= BOOT_ADDR;
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            cnt_q        <= 2'd0;
            step_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            z_q          <= z_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            parity_err_q <= parity_err_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
        end
    end

    // The strobe is a decode of the one-cycle READ state.
    assign bus.rom_cs   = (state_q == S_READ);
    assign bus.rom_addr = z_q;

    assign ir         = ir_q;
    assign opcode     = ir_q[14:12];
    assign operand    = ir_q[AW-1:0];
    assign ir_valid   = ir_valid_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != S_IDLE);
    assign pc         = z_q;
    assign leds       = disp_sel ? ir_q[7:0] : ir_q[15:8];

endmodule

// File: tb/tb_acc_fetch.sv
// ---------------------------------------------------------------------------
// tb_acc_fetch
// Three acc_fetch instances share one stimulus stream and one ROM image:
//   dut0 : ROM_LAT=1, PAR_EN=1
//   dut1 : ROM_LAT=3, PAR_EN=1
//   dut2 : ROM_LAT=1, PAR_EN=0
// Each instance has its own latency-accurate ROM model. Stimulus pushes the
// expected ROM reads and fetch results into per-instance queues; a monitor
// pops and compares whenever an instance strobes the ROM or pulses ir_valid.
// ---------------------------------------------------------------------------
module tb_acc_fetch;

    localparam int NDUT = 3;
    localparam int LAT_T [NDUT] = '{1, 3, 1};
    localparam bit PAR_T [NDUT] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        int          cyc;
        logic [15:0] ir;
        logic [11:0] pc;
        logic        par;
    } fexp_t;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        pc_load;
    logic [11:0] pc_din;
    logic        disp_sel;

    logic [15:0] ir_w     [NDUT];
    logic [2:0]  op_w     [NDUT];
    logic [11:0] opd_w    [NDUT];
    logic        iv_w     [NDUT];
    logic        pe_w     [NDUT];
    logic        busy_w   [NDUT];
    logic [11:0] pc_w     [NDUT];
    logic [7:0]  leds_w   [NDUT];
    logic        cs_w     [NDUT];
    logic [11:0] addr_w   [NDUT];

    logic [15:0] mem [0:4095];

    fexp_t fq [NDUT][$];
    rexp_t rq [NDUT][$];

    int cyc = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        acc_fetch_if #(.AW(12), .DW(16)) bus ();
        logic [15:0] pd [3];
        logic        pv [3];

        acc_fetch #(
            .AW(12), .DW(16), .BOOT_ADDR(12'h800),
            .ROM_LAT(LAT_T[gi]), .PAR_EN(PAR_T[gi])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .step(step),
            .pc_load(pc_load),
            .pc_din(pc_din),
            .bus(bus),
            .ir(ir_w[gi]),
            .opcode(op_w[gi]),
            .operand(opd_w[gi]),
            .ir_valid(iv_w[gi]),
            .parity_err(pe_w[gi]),
            .busy(busy_w[gi]),
            .pc(pc_w[gi]),
            .disp_sel(disp_sel),
            .leds(leds_w[gi])
        );

        // ROM: data is only valid in the single cycle LAT cycles after the
        // strobe; otherwise a poison word is returned.
        always @(posedge clk) begin
            pv[0] <= bus.rom_cs;
            pd[0] <= mem[bus.rom_addr];
            pv[1] <= pv[0];
            pd[1] <= pd[0];
            pv[2] <= pv[1];
            pd[2] <= pd[1];
        end
        assign bus.rom_data = pv[LAT_T[gi]-1] ? pd[LAT_T[gi]-1] : 16'hDEAD;
        assign cs_w[gi]     = bus.rom_cs;
        assign addr_w[gi]   = bus.rom_addr;
    end

    task automatic chk(input int d, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL dut%0d %s: got %h, expected %h (cycle %0d)",
                      d, name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        fexp_t fe;
        rexp_t re;
        logic [7:0] exp_leds;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (cs_w[d] === 1'b1) begin
                    if (rq[d].size() == 0) begin
                        chk(d, "rom_read_pending", 32'(rq[d].size()), 32'd1);
                    end else begin
                        re = rq[d].pop_front();
                        $display("dut%0d rom read @%0d addr=%h", d, cyc, addr_w[d]);
                        chk(d, "rom_read_cycle", 32'(cyc), 32'(re.cyc));
                        chk(d, "rom_read_addr", 32'(addr_w[d]), 32'(re.addr));
                        chk(d, "busy_in_read", 32'(busy_w[d]), 32'd1);
                    end
                end
                if (iv_w[d] === 1'b1) begin
                    if (fq[d].size() == 0) begin
                        chk(d, "fetch_pending", 32'(fq[d].size()), 32'd1);
                    end else begin
                        fe = fq[d].pop_front();
                        exp_leds = disp_sel ? fe.ir[7:0] : fe.ir[15:8];
                        $display("dut%0d fetch @%0d ir=%h pc=%h par=%b",
                                 d, cyc, ir_w[d], pc_w[d], pe_w[d]);
                        chk(d, "ir_valid_cycle", 32'(cyc), 32'(fe.cyc));
                        chk(d, "ir", 32'(ir_w[d]), 32'(fe.ir));
                        chk(d, "opcode", 32'(op_w[d]), 32'(fe.ir[14:12]));
                        chk(d, "operand", 32'(opd_w[d]), 32'(fe.ir[11:0]));
                        chk(d, "pc_after", 32'(pc_w[d]), 32'(fe.pc));
                        chk(d, "parity_err", 32'(pe_w[d]), 32'(fe.par));
                        chk(d, "leds", 32'(leds_w[d]), 32'(exp_leds));
                        chk(d, "busy_at_valid", 32'(busy_w[d]), 32'd0);
                    end
                end
            end
        end
    endtask

    // Record the read at n+1 and the fetch result at n+2+ROM_LAT.
    task automatic expect_fetch(input int n, input logic [11:0] addr,
                                input logic [15:0] w, input logic p1);
        rexp_t re;
        fexp_t fe;
        for (int d = 0; d < NDUT; d++) begin
            re.cyc  = n + 1;
            re.addr = addr;
            rq[d].push_back(re);
            fe.cyc = n + 2 + LAT_T[d];
            fe.ir  = w;
            fe.pc  = addr + 12'd1;
            fe.par = PAR_T[d] ? p1 : 1'b0;
            fq[d].push_back(fe);
        end
    endtask

    task automatic fetch(input logic [11:0] addr, input logic [15:0] w,
                         input logic p1);
        expect_fetch(cyc, addr, w, p1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(10);
    endtask

    task automatic chk_all(input string name, input int sel,
                           input logic [31:0] exp);
        for (int d = 0; d < NDUT; d++) begin
            case (sel)
                0: chk(d, name, 32'(ir_w[d]), exp);
                1: chk(d, name, 32'(pc_w[d]), exp);
                2: chk(d, name, 32'(busy_w[d]), exp);
                3: chk(d, name, 32'(pe_w[d]), exp);
                4: chk(d, name, 32'(leds_w[d]), exp);
                5: chk(d, name, 32'(iv_w[d]), exp);
                default: chk(d, name, 32'(cs_w[d]), exp);
            endcase
        end
    endtask

    initial begin
        rexp_t re;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h800] = 16'hA5C3;   // 8 ones -> parity error
        mem[12'h801] = 16'h8001;   // 2 ones -> parity error
        mem[12'h802] = 16'h0001;   // 1 one  -> ok
        mem[12'h803] = 16'h7E5B;   // 11 ones -> ok
        mem[12'hFFF] = 16'h1234;   // 5 ones -> ok
        mem[12'h000] = 16'h0F0F;   // 8 ones -> parity error
        mem[12'h001] = 16'h3C01;   // 5 ones -> ok
        mem[12'h002] = 16'hFFFF;

        rst = 1'b0; step = 1'b0; pc_load = 1'b0; pc_din = 12'h000; disp_sel = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        rst = 1'b1;
        tick(1);
        chk_all("reset_ir", 0, 32'h0);
        chk_all("reset_pc", 1, 32'h800);
        chk_all("reset_busy", 2, 32'h0);
        chk_all("reset_parity", 3, 32'h0);
        chk_all("reset_ir_valid", 5, 32'h0);
        chk_all("reset_rom_cs", 6, 32'h0);

        // First fetch and LED byte select
        fetch(12'h800, 16'hA5C3, 1'b1);
        chk_all("leds_hi", 4, 32'hA5);
        disp_sel = 1'b1;
        tick(1);
        chk_all("leds_lo", 4, 32'hC3);
        disp_sel = 1'b0;
        chk_all("pc_801", 1, 32'h801);

        // Parity pair
        fetch(12'h801, 16'h8001, 1'b1);
        fetch(12'h802, 16'h0001, 1'b0);

        // Step held for 1000 cycles: one fetch only
        expect_fetch(cyc, 12'h803, 16'h7E5B, 1'b0);
        step = 1'b1;
        tick(1000);
        step = 1'b0;
        tick(10);

        // Step held through reset release: no fetch until a new press
        step = 1'b1;
        rst  = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(20);
        chk_all("pc_after_reset_held", 1, 32'h800);
        chk_all("busy_after_reset_held", 2, 32'h0);
        step = 1'b0;
        tick(2);
        fetch(12'h800, 16'hA5C3, 1'b1);

        // pc_load with a simultaneous press: load only
        pc_load = 1'b1;
        pc_din  = 12'hFFF;
        step    = 1'b1;
        tick(1);
        pc_load = 1'b0;
        tick(1);
        step = 1'b0;
        tick(5);
        chk_all("pc_loaded", 1, 32'hFFF);
        chk_all("busy_after_load", 2, 32'h0);

        // Wrap FFF -> 000 -> 001
        fetch(12'hFFF, 16'h1234, 1'b0);
        fetch(12'h000, 16'h0F0F, 1'b1);
        chk_all("pc_wrapped", 1, 32'h001);

        // Press and pc_load while busy are ignored
        expect_fetch(cyc, 12'h001, 16'h3C01, 1'b0);
        step = 1'b1;
        tick(1);
        step    = 1'b0;
        pc_load = 1'b1;
        pc_din  = 12'h555;
        tick(1);
        pc_load = 1'b0;
        step    = 1'b1;
        tick(10);
        step = 1'b0;
        tick(5);
        chk_all("pc_busy_ignored", 1, 32'h002);

        // Reset during the first WAIT cycle aborts the fetch
        for (int d = 0; d < NDUT; d++) begin
            re.cyc  = cyc + 1;
            re.addr = 12'h002;
            rq[d].push_back(re);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(6);
        chk_all("abort_ir", 0, 32'h0);
        chk_all("abort_pc", 1, 32'h800);
        chk_all("abort_parity", 3, 32'h0);
        fetch(12'h800, 16'hA5C3, 1'b1);

        // Everything expected must have been observed
        tick(10);
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "fetches_outstanding", 32'(fq[d].size()), 32'd0);
            chk(d, "reads_outstanding", 32'(rq[d].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
